bit_serial_adder_ctrl: RTL and testbench
========================================

# bit_serial_adder_ctrl

Bit-serial adder controller. It drives a single 1-bit full-adder slice (sum = x^y^z, carry = majority(x,y,z)) over WIDTH operand bits, LSB first, one bit per clock. A registered carry closes the loop between bit steps. Operands enter and results leave through valid/ready handshakes, so the block drops in wherever the design trades adder area for latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and cin valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum/cout valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result word, registered.
- cout  output  1  carry out of bit WIDTH-1, registered.
- busy  output  1  high in RUN or DONE.
- sub  input  1  present only with ADDSUB_EN; sampled with operands.

## Operation
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: latch a into shift register A and b into shift register B.
  - Load the carry flop with cin, clear the bit counter to 0, go to RUN.
- RUN, each cycle:
  - Feed the full adder with x=A[0], y=B[0], z=carry.
  - Shift the slice sum into sum_sr from the MSB end. After WIDTH shifts, bit 0 sits at sum_sr[0].
  - carry <= slice carry. A and B shift right by 1. Counter increments.
  - When counter==WIDTH-1 (last bit): register sum and cout from the final shift and go to DONE.
  - Counter width is clog2(WIDTH) bits. The counter never wraps inside an operation.
- DONE
  - out_valid=1. sum and cout stay stable until out_valid&&out_ready, then go to IDLE.
  - in_valid is ignored outside IDLE. Operands presented in RUN or DONE are not captured.
- Arithmetic is modulo 2^WIDTH. cout is the true carry out. No overflow flag.
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, sum=0, cout=0; internal carry, counter and shift registers = 0.
- Reset mid-operation, in RUN or DONE: the operation is aborted with no result emitted. The next cycle is IDLE with the reset values.
- Output accept and new input in the same cycle: not possible, because in_ready=0 in DONE. The new operand is accepted on the first IDLE cycle after the output handshake.

## Timing
- Accept edge at cycle T (in_valid&&in_ready sampled high).
- RUN occupies cycles T+1..T+WIDTH.
- out_valid rises at T+WIDTH+1. For WIDTH=8 that is 9 cycles after accept.
- Output handshake at cycle U puts the block in IDLE, with in_ready=1, at U+1.
- Best-case throughput: one operation per WIDTH+2 cycles, with out_ready tied high.
- Every output is driven directly from a flop. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- ADDSUB_EN defined:
  - Adds the sub port, latched at accept.
  - When sub=1, B is stored inverted and the carry flop loads 1, ignoring cin. The result is a-b mod 2^WIDTH; cout=1 means no borrow.
- ADDSUB_EN undefined:
  - No sub port. The block is an adder only, and cin is always used.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0, out_ready=1 -> out_valid exactly 9 cycles after accept; sum=0x8D, cout=0; in_ready=1 the cycle after the handshake.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- out_ready held low for 5 cycles in DONE -> out_valid, sum and cout stay stable; in_ready=0 and in_valid is ignored; the result retires on the cycle out_ready rises.
- rst asserted for 1 cycle while the counter is at 3 -> next cycle in_ready=1, busy=0, out_valid=0, sum=0; a following operation 0x01+0x01 gives 0x02.
- in_valid held high with random operands, checked against a reference model over 1000 operations -> every result matches a+b+cin mod 256, and no operand is lost or duplicated.
- With ADDSUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. sub=1, a=0x00, b=0x01 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/bit_serial_adder_ctrl.sv
// ============================================================================
// Module   : bit_serial_adder_ctrl
// Function : Bit-serial adder controller. It drives one full-adder slice over
//            WIDTH bits, LSB first. Optional ADDSUB_EN adds subtraction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef ADDSUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic             slice_x, slice_y, slice_z;
  logic             slice_sum, slice_carry;

  assign accept   = in_valid_i && in_ready_q;
  assign last_bit = (cnt_q == c_LAST_BIT);

  assign slice_x     = a_sr_q[0];
  assign slice_y     = b_sr_q[0];
  assign slice_z     = carry_q;
  assign slice_sum   = slice_x ^ slice_y ^ slice_z;
  assign slice_carry = (slice_x & slice_y) | (slice_x & slice_z) | (slice_y & slice_z);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (accept)      state_d = c_RUN;
      c_RUN:  if (last_bit)    state_d = c_DONE;
      c_DONE: if (out_ready_i) state_d = c_IDLE;
      default:                 state_d = c_IDLE;
    endcase
  end

  // Status flags are decoded from the next state and registered, so every
  // output leaves the block straight from a flop.
  always_comb begin
    in_ready_d  = (state_d == c_IDLE);
    out_valid_d = (state_d == c_DONE);
    busy_d      = (state_d == c_RUN) || (state_d == c_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (accept) begin
          a_sr_d = a_i;
          cnt_d  = '0;
`ifdef ADDSUB_EN
          // Two's-complement subtraction: a + ~b + 1.
          if (sub_i) begin
            b_sr_d  = ~b_i;
            carry_d = 1'b1;
          end else begin
            b_sr_d  = b_i;
            carry_d = cin_i;
          end
`else
          b_sr_d  = b_i;
          carry_d = cin_i;
`endif
        end
      end
      c_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {slice_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = slice_carry;
        if (last_bit) begin
          cout_d = slice_carry;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  // The sum shift register only moves in RUN, so it doubles as the result
  // register and holds the word steady through DONE.
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign sum_o       = sum_sr_q;
  assign cout_o      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_adder_ctrl.sv
// ============================================================================
// Module   : tb_bit_serial_adder_ctrl
// Function : Self-checking bench for bit_serial_adder_ctrl (WIDTH=8); covers
//            ADDSUB_EN when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
`ifdef ADDSUB_EN
    .sub_i       (sub),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result from plain arithmetic: {cout, sum}.
  function automatic logic [W:0] ref_result(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                            input logic ic, input logic isub);
    logic [W:0] r;
`ifdef ADDSUB_EN
    if (isub) begin
      r[W-1:0] = ia - ib;
      r[W]     = (ia >= ib);
      return r;
    end
`endif
    r = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    return r;
  endfunction

  task automatic accept_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic ic, input logic isub);
    int guard;
    a = ia; b = ib; cin = ic; sub = isub;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (sum !== 8'h00)      begin n_err++; $display("FAIL reset_sum: got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0)      begin n_err++; $display("FAIL reset_cout: got %b want 0", cout); end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    accept_op(8'h5A, 8'h33, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_run_flags: busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    wait_done(lat);
    n_cmp++; if (lat != 9)       begin n_err++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++; if (sum !== 8'h8D)  begin n_err++; $display("FAIL basic_sum: got %h want 8d", sum); end
    n_cmp++; if (cout !== 1'b0)  begin n_err++; $display("FAIL basic_cout: got %b want 0", cout); end
    step();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_after_hs: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                        in_ready, out_valid, busy);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [4] = '{8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [W-1:0] tb [4] = '{8'h01, 8'hFF, 8'h00, 8'h80};
    logic         tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] es [4] = '{8'h00, 8'hFF, 8'h01, 8'h00};
    logic         ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept_op(ta[i], tb[i], tc[i], 1'b0);
      wait_done(lat);
      n_cmp++; if (sum !== es[i] || cout !== ec[i]) begin
        n_err++; $display("FAIL boundary_%0d: got sum=%h cout=%b want sum=%h cout=%b",
                          i, sum, cout, es[i], ec[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    accept_op(8'h12, 8'h34, 1'b1, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'b1;
      step();
      n_cmp++; if (out_valid !== 1'b1 || sum !== 8'h47 || cout !== 1'b0 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL backpressure_hold_%0d: out_valid=%b sum=%h cout=%b in_ready=%b want 1/47/0/0",
                          i, out_valid, sum, cout, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL backpressure_retire: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                        in_ready, out_valid, busy);
    end
    step();
    n_cmp++; if (busy !== 1'b0) begin
      n_err++; $display("FAIL backpressure_no_capture: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    accept_op(8'hF0, 8'h0F, 1'b0, 1'b0);
    step(); step(); step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h00) begin
      n_err++; $display("FAIL midreset_state: in_ready=%b busy=%b out_valid=%b sum=%h want 1/0/0/00",
                        in_ready, busy, out_valid, sum);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid !== 1'b0) begin
        n_cmp++; n_err++; $display("FAIL midreset_spurious_result: out_valid=%b want 0", out_valid);
      end
    end
    accept_op(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (sum !== 8'h02 || cout !== 1'b0 || lat != 9) begin
      n_err++; $display("FAIL midreset_followup: sum=%h cout=%b lat=%0d want 02/0/9", sum, cout, lat);
    end
    step();
  endtask

`ifdef ADDSUB_EN
  task automatic test_addsub();
    int lat;
    out_ready = 1'b1;
    accept_op(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done(lat);
    n_cmp++; if (sum !== 8'h0F || cout !== 1'b1) begin
      n_err++; $display("FAIL sub_10_01: sum=%h cout=%b want 0f/1", sum, cout);
    end
    step();
    accept_op(8'h00, 8'h01, 1'b1, 1'b1);
    wait_done(lat);
    n_cmp++; if (sum !== 8'hFF || cout !== 1'b0) begin
      n_err++; $display("FAIL sub_00_01: sum=%h cout=%b want ff/0", sum, cout);
    end
    step();
  endtask
`endif

  task automatic test_random();
    logic [W:0]   q[$];
    logic [W:0]   exp;
    logic         acc, ret;
    logic [W-1:0] s_sum;
    logic         s_cout;
    int retired = 0;
    int accepted = 0;
    int cyc = 0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef ADDSUB_EN
    sub = 1'($urandom);
`else
    sub = 1'b0;
`endif
    in_valid = 1'b1;
    while (retired < 1000 && cyc < 40000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      acc    = in_valid && in_ready;
      ret    = out_valid && out_ready;
      s_sum  = sum;
      s_cout = cout;
      exp    = ref_result(a, b, cin, sub);
      step();
      cyc++;
      if (ret) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL random_spurious: result %h/%b with nothing pending", s_sum, s_cout);
        end else begin
          logic [W:0] e;
          e = q.pop_front();
          n_cmp++; if ({s_cout, s_sum} !== e) begin
            n_err++; $display("FAIL random_op_%0d: got cout=%b sum=%h want cout=%b sum=%h",
                              retired, s_cout, s_sum, e[W], e[W-1:0]);
          end
        end
        retired++;
      end
      if (acc) begin
        q.push_back(exp);
        accepted++;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef ADDSUB_EN
        sub = 1'($urandom);
`endif
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (retired != 1000) begin
      n_err++; $display("FAIL random_count: retired %0d want 1000", retired);
    end
    n_cmp++; if (accepted - retired > 1 || accepted < retired) begin
      n_err++; $display("FAIL random_loss: accepted %0d retired %0d want difference 0..1", accepted, retired);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL random_drain: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
`ifdef ADDSUB_EN
    test_addsub();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
